// File: rtl/pi_estimator_if.sv
// Control, sample and result bundle for the Monte Carlo pi estimator.
interface pi_estimator_if;
    logic        start;
    logic        sample_valid;
    logic [8:0]  sample_x;
    logic [8:0]  sample_y;
    logic        busy;
    logic [19:0] hits;
    logic [19:0] total;
    logic [15:0] pi_q;
    logic        pi_valid;

    modport master (
        output start, sample_valid, sample_x, sample_y,
        input  busy, hits, total, pi_q, pi_valid
    );

    modport slave (
        input  start, sample_valid, sample_x, sample_y,
        output busy, hits, total, pi_q, pi_valid
    );
endinterface

// File: rtl/pi_estimator.sv
// Monte Carlo pi estimator: counts random points inside a quarter circle,
// then divides hits by total to produce pi in unsigned Q4.12.
module pi_estimator #(
    parameter int unsigned N_SAMPLES = 100000,
    parameter int unsigned RADIUS    = 480
) (
    input logic           clk,
    input logic           reset,
    pi_estimator_if.slave bus
);
    localparam logic [19:0] N_LIMIT = 20'(N_SAMPLES);
    localparam logic [9:0]  RAD     = 10'(RADIUS);
    localparam logic [18:0] RAD_SQ  = 19'(RADIUS * RADIUS);

    typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;
    state_t state;

    logic        s1_valid;
    logic        s1_in_square;
    logic [17:0] s1_x2;
    logic [17:0] s1_y2;

    logic [19:0] hits;
    logic [19:0] total;
    logic [15:0] pi_q;
    logic        pi_valid;
    logic        busy;

    logic [19:0] rem;
    logic [19:0] divisor;
    logic [15:0] dlow;
    logic [15:0] quo;
    logic [3:0]  iter;

    logic [18:0] sum;
    logic        counted;
    logic        in_circle;
    logic [19:0] hits_inc;
    logic [19:0] total_inc;
    logic [20:0] trial;
    logic        ge;
    logic [19:0] diff;
    logic [19:0] rem_next;
    logic [15:0] quo_next;

    always_comb begin
        sum       = {1'b0, s1_x2} + {1'b0, s1_y2};
        counted   = s1_valid && s1_in_square && (state == ACCUM);
        in_circle = (sum <= RAD_SQ);
        hits_inc  = hits + {19'd0, in_circle};
        total_inc = total + 20'd1;
        // Only low 20 bits of the difference matter: when ge, the true result is below divisor.
        trial     = {rem, dlow[15]};
        ge        = (trial >= {1'b0, divisor});
        diff      = trial[19:0] - divisor;
        rem_next  = ge ? diff : trial[19:0];
        quo_next  = {quo[14:0], ge};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            s1_valid     <= 1'b0;
            s1_in_square <= 1'b0;
            s1_x2        <= '0;
            s1_y2        <= '0;
            hits         <= '0;
            total        <= '0;
            pi_q         <= '0;
            pi_valid     <= 1'b0;
            busy         <= 1'b0;
            rem          <= '0;
            divisor      <= '0;
            dlow         <= '0;
            quo          <= '0;
            iter         <= '0;
        end else begin
            pi_valid <= 1'b0;
            s1_valid <= 1'b0;
            if (bus.start) begin
                state <= ACCUM;
                busy  <= 1'b1;
                hits  <= '0;
                total <= '0;
            end else begin
                case (state)
                    IDLE: busy <= 1'b0;
                    ACCUM: begin
                        s1_valid     <= bus.sample_valid;
                        s1_in_square <= ({1'b0, bus.sample_x} < RAD) && ({1'b0, bus.sample_y} < RAD);
                        s1_x2        <= {9'd0, bus.sample_x} * {9'd0, bus.sample_x};
                        s1_y2        <= {9'd0, bus.sample_y} * {9'd0, bus.sample_y};
                        if (counted) begin
                            total <= total_inc;
                            hits  <= hits_inc;
                            if (total_inc == N_LIMIT) begin
                                // hits <= total, so the top 18 quotient bits are zero:
                                // seed the remainder with dividend>>16 and iterate the low 16 bits.
                                state    <= DIVIDE;
                                s1_valid <= 1'b0;
                                rem      <= {2'b00, hits_inc[19:2]};
                                dlow     <= {hits_inc[1:0], 14'd0};
                                divisor  <= total_inc;
                                quo      <= '0;
                                iter     <= '0;
                            end
                        end
                    end
                    DIVIDE: begin
                        rem  <= rem_next;
                        dlow <= {dlow[14:0], 1'b0};
                        quo  <= quo_next;
                        iter <= iter + 4'd1;
                        if (iter == 4'd15) begin
                            state    <= DONE;
                            pi_q     <= quo_next;
                            pi_valid <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy     = busy;
    assign bus.hits     = hits;
    assign bus.total    = total;
    assign bus.pi_q     = pi_q;
    assign bus.pi_valid = pi_valid;
endmodule

// File: tb/tb_pi_estimator.sv
// Directed bench for pi_estimator: three instances (N=4, N=2, N=30000) share one stimulus stream.
module tb_pi_estimator;
    localparam int unsigned NR = 30000;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       sv;
    logic [8:0] sx;
    logic [8:0] sy;
    int         total_n = 0;
    int         bad = 0;
    int         pv4 = 0;
    int         pv2 = 0;

    always #5 clk = ~clk;

    pi_estimator_if a4 ();
    pi_estimator_if a2 ();
    pi_estimator_if ar ();

    assign a4.start = start;
    assign a4.sample_valid = sv;
    assign a4.sample_x = sx;
    assign a4.sample_y = sy;
    assign a2.start = start;
    assign a2.sample_valid = sv;
    assign a2.sample_x = sx;
    assign a2.sample_y = sy;
    assign ar.start = start;
    assign ar.sample_valid = sv;
    assign ar.sample_x = sx;
    assign ar.sample_y = sy;

    pi_estimator #(.N_SAMPLES(4), .RADIUS(480)) u4 (.clk(clk), .reset(reset), .bus(a4.slave));
    pi_estimator #(.N_SAMPLES(2), .RADIUS(480)) u2 (.clk(clk), .reset(reset), .bus(a2.slave));
    pi_estimator #(.N_SAMPLES(NR), .RADIUS(480)) ur (.clk(clk), .reset(reset), .bus(ar.slave));

    always @(posedge clk) begin
        if (a4.pi_valid === 1'b1) pv4 <= pv4 + 1;
        if (a2.pi_valid === 1'b1) pv2 <= pv2 + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic put(input logic [8:0] x, input logic [8:0] y);
        sv = 1'b1;
        sx = x;
        sy = y;
        step();
        sv = 1'b0;
    endtask

    // k = cycles after the sample-presenting cycle at which pi_valid is seen, -1 if none within 40
    task automatic wait_valid(input int sel, output int k);
        logic v;
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            v = (sel == 0) ? a4.pi_valid : (sel == 1) ? a2.pi_valid : ar.pi_valid;
            if (v === 1'b1) begin
                k = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sv = 1'b0; sx = '0; sy = '0;
        repeat (3) step();
        total_n++; if (a4.hits !== 20'd0) begin bad++; $display("FAIL reset_hits got=%0d want=0", a4.hits); end
        total_n++; if (a4.total !== 20'd0) begin bad++; $display("FAIL reset_total got=%0d want=0", a4.total); end
        total_n++; if (a4.pi_q !== 16'h0000) begin bad++; $display("FAIL reset_pi_q got=%0h want=0", a4.pi_q); end
        total_n++; if (a4.pi_valid !== 1'b0) begin bad++; $display("FAIL reset_pi_valid got=%b want=0", a4.pi_valid); end
        total_n++; if (a4.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", a4.busy); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int k;
        int base;
        pulse_start();
        total_n++; if (a4.busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", a4.busy); end
        base = pv4;
        put(9'd0, 9'd0);
        put(9'd479, 9'd0);
        put(9'd400, 9'd400);
        put(9'd100, 9'd100);
        wait_valid(0, k);
        total_n++; if (k != 17) begin bad++; $display("FAIL basic_latency got=%0d want=17", k); end
        total_n++; if (a4.hits !== 20'd3) begin bad++; $display("FAIL basic_hits got=%0d want=3", a4.hits); end
        total_n++; if (a4.total !== 20'd4) begin bad++; $display("FAIL basic_total got=%0d want=4", a4.total); end
        total_n++; if (a4.pi_q !== 16'h3000) begin bad++; $display("FAIL basic_pi_q got=%0h want=3000", a4.pi_q); end
        step();
        total_n++; if (a4.pi_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse_width got=%b want=0", a4.pi_valid); end
        total_n++; if (a4.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_done got=%b want=0", a4.busy); end
        repeat (5) step();
        total_n++; if (pv4 - base != 1) begin bad++; $display("FAIL basic_pulse_count got=%0d want=1", pv4 - base); end
        total_n++; if (a2.pi_q !== 16'h4000) begin bad++; $display("FAIL n2_first_two got=%0h want=4000", a2.pi_q); end
    endtask

    task automatic test_out_of_square();
        int k;
        pulse_start();
        put(9'd10, 9'd10);
        put(9'd480, 9'd0);
        put(9'd10, 9'd10);
        put(9'd0, 9'd500);
        put(9'd10, 9'd10);
        put(9'd480, 9'd0);
        put(9'd10, 9'd10);
        wait_valid(0, k);
        total_n++; if (k != 17) begin bad++; $display("FAIL oos_latency got=%0d want=17", k); end
        total_n++; if (a4.total !== 20'd4) begin bad++; $display("FAIL oos_total got=%0d want=4", a4.total); end
        total_n++; if (a4.hits !== 20'd4) begin bad++; $display("FAIL oos_hits got=%0d want=4", a4.hits); end
        total_n++; if (a4.pi_q !== 16'h4000) begin bad++; $display("FAIL oos_pi_q got=%0h want=4000", a4.pi_q); end
        repeat (3) step();
        put(9'd0, 9'd0);
        repeat (3) step();
        total_n++; if (a4.total !== 20'd4) begin bad++; $display("FAIL idle_ignore_total got=%0d want=4", a4.total); end
        total_n++; if (a4.hits !== 20'd4) begin bad++; $display("FAIL idle_ignore_hits got=%0d want=4", a4.hits); end
    endtask

    task automatic test_all_miss();
        int k;
        pulse_start();
        put(9'd479, 9'd479);
        put(9'd479, 9'd479);
        wait_valid(1, k);
        total_n++; if (k != 17) begin bad++; $display("FAIL miss_latency got=%0d want=17", k); end
        total_n++; if (a2.hits !== 20'd0) begin bad++; $display("FAIL miss_hits got=%0d want=0", a2.hits); end
        total_n++; if (a2.total !== 20'd2) begin bad++; $display("FAIL miss_total got=%0d want=2", a2.total); end
        total_n++; if (a2.pi_q !== 16'h0000) begin bad++; $display("FAIL miss_pi_q got=%0h want=0", a2.pi_q); end
        repeat (3) step();
    endtask

    task automatic test_abort_divide();
        int k;
        int base;
        pulse_start();
        repeat (4) put(9'd1, 9'd1);
        repeat (7) step();
        start = 1'b1; sv = 1'b1; sx = 9'd0; sy = 9'd0;
        step();
        start = 1'b0; sv = 1'b0;
        total_n++; if (a4.busy !== 1'b1) begin bad++; $display("FAIL abort_busy got=%b want=1", a4.busy); end
        total_n++; if (a4.hits !== 20'd0) begin bad++; $display("FAIL abort_hits got=%0d want=0", a4.hits); end
        base = pv4;
        repeat (2) step();
        total_n++; if (a4.total !== 20'd0) begin bad++; $display("FAIL start_priority_total got=%0d want=0", a4.total); end
        repeat (20) step();
        total_n++; if (pv4 != base) begin bad++; $display("FAIL abort_no_pulse got=%0d want=0", pv4 - base); end
        total_n++; if (a4.pi_q !== 16'h4000) begin bad++; $display("FAIL abort_pi_q_kept got=%0h want=4000", a4.pi_q); end
        total_n++; if (a4.busy !== 1'b1) begin bad++; $display("FAIL abort_busy_accum got=%b want=1", a4.busy); end
        put(9'd0, 9'd0);
        put(9'd400, 9'd400);
        put(9'd400, 9'd400);
        put(9'd0, 9'd0);
        wait_valid(0, k);
        total_n++; if (k != 17) begin bad++; $display("FAIL rerun_latency got=%0d want=17", k); end
        total_n++; if (a4.hits !== 20'd2) begin bad++; $display("FAIL rerun_hits got=%0d want=2", a4.hits); end
        total_n++; if (a4.pi_q !== 16'h2000) begin bad++; $display("FAIL rerun_pi_q got=%0h want=2000", a4.pi_q); end
        repeat (3) step();
    endtask

    task automatic test_reset_mid_run();
        int base;
        pulse_start();
        repeat (3) put(9'd0, 9'd0);
        repeat (2) step();
        total_n++; if (a4.total !== 20'd3) begin bad++; $display("FAIL mid_total got=%0d want=3", a4.total); end
        reset = 1'b1; start = 1'b1;
        step();
        reset = 1'b0; start = 1'b0;
        total_n++; if (a4.hits !== 20'd0) begin bad++; $display("FAIL rst_mid_hits got=%0d want=0", a4.hits); end
        total_n++; if (a4.total !== 20'd0) begin bad++; $display("FAIL rst_mid_total got=%0d want=0", a4.total); end
        total_n++; if (a4.pi_q !== 16'h0000) begin bad++; $display("FAIL rst_mid_pi_q got=%0h want=0", a4.pi_q); end
        total_n++; if (a4.pi_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_pi_valid got=%b want=0", a4.pi_valid); end
        total_n++; if (a4.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", a4.busy); end
        base = pv4;
        repeat (4) put(9'd0, 9'd0);
        repeat (20) step();
        total_n++; if (a4.total !== 20'd0) begin bad++; $display("FAIL rst_ignore_total got=%0d want=0", a4.total); end
        total_n++; if (pv4 != base) begin bad++; $display("FAIL rst_ignore_pulse got=%0d want=0", pv4 - base); end
    endtask

    task automatic test_random();
        logic [31:0] lfsr;
        int          k;
        int          mt;
        int          mh;
        int          xi;
        int          yi;
        longint      expq;
        longint      diffq;
        lfsr = 32'hACE1_2345;
        mt = 0;
        mh = 0;
        pulse_start();
        for (int n = 0; n < 60000 && mt < int'(NR); n++) begin
            xi = int'(lfsr[8:0]);
            yi = int'(lfsr[17:9]);
            put(lfsr[8:0], lfsr[17:9]);
            if (xi < 480 && yi < 480) begin
                mt++;
                if (xi * xi + yi * yi <= 230400) mh++;
            end
            for (int j = 0; j < 18; j++)
                lfsr = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
        end
        wait_valid(2, k);
        expq = (longint'(mh) << 14) / longint'((mt == 0) ? 1 : mt);
        total_n++; if (k != 17) begin bad++; $display("FAIL rand_latency got=%0d want=17", k); end
        total_n++; if (ar.total !== 20'(mt)) begin bad++; $display("FAIL rand_total got=%0d want=%0d", ar.total, mt); end
        total_n++; if (ar.hits !== 20'(mh)) begin bad++; $display("FAIL rand_hits got=%0d want=%0d", ar.hits, mh); end
        total_n++; if (ar.pi_q !== 16'(expq)) begin bad++; $display("FAIL rand_pi_q got=%0h want=%0h", ar.pi_q, expq); end
        diffq = longint'(ar.pi_q) - 64'sh3244;
        if (diffq < 0) diffq = -diffq;
        total_n++; if (diffq > 64'sh80) begin bad++; $display("FAIL rand_accuracy got=%0h want=3244+-80", ar.pi_q); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_out_of_square();
        test_all_miss();
        test_abort_divide();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total_n, bad);
        $finish;
    end
endmodule
